// File: rtl/ucounter16_seq.sv
// Interval-timer sequencer driving a ucounter16: one-shot or periodic, up or down, preset to target.
// Optional pause support is compiled in with `define UCOUNTER16_SEQ_PAUSE_EN.
module ucounter16_seq #(
   parameter int SIZE   = 16,
   parameter int PCNT_W = 8
) (
   input  logic              clk,
   input  logic              _reset,
   input  logic              start,
   input  logic              abort,
   input  logic [SIZE-1:0]   preset,
   input  logic [SIZE-1:0]   target,
   input  logic              dir,
   input  logic              periodic,
   input  logic              pause,
   input  logic [SIZE-1:0]   dcount,
   input  logic              overflow,
   output logic              ctr_areset,
   output logic              ctr_aset,
   output logic              ctr_load,
   output logic [SIZE-1:0]   ctr_preld_val,
   output logic              ctr_updown,
   output logic              ctr_wrapstop,
   output logic              ctr_carry_in,
   output logic              busy,
   output logic              done,
   output logic              tick,
   output logic [PCNT_W-1:0] period_cnt,
   output logic              err
);

   typedef enum logic [1:0] {CLEAR, IDLE, LOAD, RUN} state_t;

   state_t            state_reg, state_next;
   logic [SIZE-1:0]   preset_reg, preset_next;
   logic [SIZE-1:0]   target_reg, target_next;
   logic              dir_reg, dir_next;
   logic              periodic_reg, periodic_next;
   logic [PCNT_W-1:0] period_cnt_reg, period_cnt_next;
   logic              err_reg, err_next;
   logic              done_reg, done_next;
   logic              tick_reg, tick_next;

   logic pause_eff;
   logic match;
   logic match_eff;
   logic ovf_eff;

`ifdef UCOUNTER16_SEQ_PAUSE_EN
   assign pause_eff = pause;
`else
   logic unused_pause;
   assign unused_pause = pause;
   assign pause_eff    = 1'b0;
`endif

   // While paused, neither match nor overflow is acted on; dcount is simply held.
   assign match     = (dcount == target_reg);
   assign match_eff = match & ~pause_eff;
   assign ovf_eff   = overflow & ~pause_eff;

   always_ff @(posedge clk) begin
      if (!_reset) begin
         state_reg      <= CLEAR;
         preset_reg     <= '0;
         target_reg     <= '0;
         dir_reg        <= 1'b0;
         periodic_reg   <= 1'b0;
         period_cnt_reg <= '0;
         err_reg        <= 1'b0;
         done_reg       <= 1'b0;
         tick_reg       <= 1'b0;
      end else begin
         state_reg      <= state_next;
         preset_reg     <= preset_next;
         target_reg     <= target_next;
         dir_reg        <= dir_next;
         periodic_reg   <= periodic_next;
         period_cnt_reg <= period_cnt_next;
         err_reg        <= err_next;
         done_reg       <= done_next;
         tick_reg       <= tick_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      preset_next     = preset_reg;
      target_next     = target_reg;
      dir_next        = dir_reg;
      periodic_next   = periodic_reg;
      period_cnt_next = period_cnt_reg;
      err_next        = err_reg;
      done_next       = 1'b0;
      tick_next       = 1'b0;

      case (state_reg)
         CLEAR: state_next = IDLE;
         IDLE: begin
            if (start && !abort) begin
               preset_next     = preset;
               target_next     = target;
               dir_next        = dir;
               periodic_next   = periodic;
               period_cnt_next = '0;
               err_next        = 1'b0;
               state_next      = LOAD;
            end
         end
         LOAD: state_next = abort ? CLEAR : RUN;
         RUN: begin
            if (abort) begin
               state_next = CLEAR;
            end else if (match_eff) begin
               if (periodic_reg) begin
                  tick_next = 1'b1;
                  if (period_cnt_reg != {PCNT_W{1'b1}})
                     period_cnt_next = period_cnt_reg + 1'b1;
                  state_next = LOAD;
               end else begin
                  done_next  = 1'b1;
                  state_next = IDLE;
               end
            end else if (ovf_eff) begin
               // Counter ran into its limit without ever hitting the target.
               err_next   = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = CLEAR;
      endcase
   end

   assign ctr_areset    = (state_reg == CLEAR);
   assign ctr_aset      = 1'b0;
   assign ctr_load      = (state_reg == LOAD);
   assign ctr_preld_val = preset_reg;
   assign ctr_updown    = dir_reg;
   assign ctr_wrapstop  = periodic_reg;
   // Enable drops in the same cycle dcount reaches target, so there is no overshoot.
   assign ctr_carry_in  = (state_reg == RUN) & ~match & ~pause_eff;
   assign busy          = (state_reg == LOAD) || (state_reg == RUN);
   assign done          = done_reg;
   assign tick          = tick_reg;
   assign period_cnt    = period_cnt_reg;
   assign err           = err_reg;

endmodule

// File: tb/tb_ucounter16_seq.sv
// Directed bench for ucounter16_seq with a small behavioural ucounter16 attached.
module tb_ucounter16_seq;

   logic        clk = 1'b0;
   logic        rst_n, start, abort, dir, periodic, pause;
   logic [15:0] preset, target;
   logic [15:0] dcount;
   logic        overflow;
   logic        ctr_areset, ctr_aset, ctr_load, ctr_updown, ctr_wrapstop, ctr_carry_in;
   logic [15:0] ctr_preld_val;
   logic        busy, done, tick, err;
   logic [7:0]  period_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ucounter16_seq #(.SIZE(16), .PCNT_W(8)) dut (
      .clk(clk), ._reset(rst_n), .start(start), .abort(abort),
      .preset(preset), .target(target), .dir(dir), .periodic(periodic),
      .pause(pause), .dcount(dcount), .overflow(overflow),
      .ctr_areset(ctr_areset), .ctr_aset(ctr_aset), .ctr_load(ctr_load),
      .ctr_preld_val(ctr_preld_val), .ctr_updown(ctr_updown),
      .ctr_wrapstop(ctr_wrapstop), .ctr_carry_in(ctr_carry_in),
      .busy(busy), .done(done), .tick(tick), .period_cnt(period_cnt), .err(err)
   );

   // Attached counter: clear, load, count; stops or wraps at the limit and flags overflow.
   always @(posedge clk) begin
      if (ctr_areset) begin
         dcount <= 16'h0000; overflow <= 1'b0;
      end else if (ctr_load) begin
         dcount <= ctr_preld_val; overflow <= 1'b0;
      end else if (ctr_carry_in) begin
         if (ctr_updown) begin
            if (dcount == 16'hFFFF) begin
               overflow <= 1'b1;
               if (ctr_wrapstop) dcount <= 16'h0000;
            end else dcount <= dcount + 16'h0001;
         end else begin
            if (dcount == 16'h0000) begin
               overflow <= 1'b1;
               if (ctr_wrapstop) dcount <= 16'hFFFF;
            end else dcount <= dcount - 16'h0001;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Presents a start request; returns just after the edge that samples it.
   task automatic kick(input logic [15:0] p, input logic [15:0] t, input logic d, input logic per);
      preset = p; target = t; dir = d; periodic = per; start = 1'b1;
      step(1);
      start = 1'b0;
      preset = 16'hDEAD; target = 16'hBEEF; dir = ~d; periodic = ~per;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_done;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
      dir = 1'b0; periodic = 1'b0; preset = 16'h0; target = 16'h0;

      // Reset and release
      step(2);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_tick", tick, 0);
      check("rst_pcnt", period_cnt, 0);
      check("rst_err", err, 0);
      check("rst_areset", ctr_areset, 1);
      rst_n = 1'b1;
      #1;
      check("rel_areset_hi", ctr_areset, 1);
      step(1);
      check("idle_areset", ctr_areset, 0);
      check("idle_load", ctr_load, 0);
      check("idle_carry", ctr_carry_in, 0);
      check("idle_aset", ctr_aset, 0);
      check("idle_dcount", dcount, 16'h0000);

      // One-shot up 00FC -> 0100
      kick(16'h00FC, 16'h0100, 1'b1, 1'b0);
      check("os_load", ctr_load, 1);
      check("os_busy", busy, 1);
      check("os_preld", ctr_preld_val, 16'h00FC);
      check("os_updown", ctr_updown, 1);
      check("os_wrapstop", ctr_wrapstop, 0);
      step(1);
      check("os_dcount_fc", dcount, 16'h00FC);
      check("os_carry", ctr_carry_in, 1);
      step(4);
      check("os_dcount_100", dcount, 16'h0100);
      check("os_carry_off", ctr_carry_in, 0);
      check("os_done_early", done, 0);
      step(1);
      check("os_done", done, 1);
      check("os_busy_end", busy, 0);
      step(1);
      check("os_done_pulse", done, 0);
      check("os_dcount_hold", dcount, 16'h0100);

      // Periodic down 0005 -> 0002: tick every 5 cycles
      kick(16'h0005, 16'h0002, 1'b0, 1'b1);
      for (int k = 1; k <= 15; k++) begin
         step(1);
         check($sformatf("per_tick_c%0d", k), tick, (k % 5 == 0) ? 1 : 0);
      end
      check("per_pcnt3", period_cnt, 3);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("per_abort_busy", busy, 0);
      check("per_abort_areset", ctr_areset, 1);
      check("per_abort_pcnt", period_cnt, 3);
      step(1);

      // One-shot up FFFD -> 0001 with stop: overflow -> err
      kick(16'hFFFD, 16'h0001, 1'b1, 1'b0);
      step(4);
      check("ovf_dcount", dcount, 16'hFFFF);
      check("ovf_flag", overflow, 1);
      check("ovf_err_early", err, 0);
      step(1);
      check("ovf_err", err, 1);
      check("ovf_done", done, 0);
      check("ovf_busy", busy, 0);
      step(1);
      check("ovf_dcount_sat", dcount, 16'hFFFF);
      check("ovf_err_sticky", err, 1);

      // Periodic up 0 -> 0010, abort on 7th RUN cycle
      kick(16'h0000, 16'h0010, 1'b1, 1'b1);
      check("ab_err_clr", err, 0);
      step(7);
      check("ab_dcount6", dcount, 16'h0006);
      check("ab_busy", busy, 1);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("ab_areset", ctr_areset, 1);
      check("ab_busy_lo", busy, 0);
      step(1);
      check("ab_dcount0", dcount, 16'h0000);
      check("ab_pcnt", period_cnt, 0);
      check("ab_tick", tick, 0);

      // preset == target: done two cycles after start
      kick(16'h0042, 16'h0042, 1'b1, 1'b0);
      step(1);
      check("eq_carry", ctr_carry_in, 0);
      check("eq_done_early", done, 0);
      step(1);
      check("eq_done", done, 1);
      check("eq_dcount", dcount, 16'h0042);

      // One-shot 0 -> 8 with pause held for 3 cycles mid-run
`ifdef UCOUNTER16_SEQ_PAUSE_EN
      exp_done = 13;
`else
      exp_done = 10;
`endif
      step(1);
      kick(16'h0000, 16'h0008, 1'b1, 1'b0);
      step(3);
      pause = 1'b1;
      step(3);
      pause = 1'b0;
      for (int n = 7; n <= 14; n++) begin
         step(1);
         check($sformatf("pause_done_c%0d", n), done, (n == exp_done) ? 1 : 0);
      end
      check("pause_dcount", dcount, 16'h0008);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
